// File: rtl/spi_reg_loader.sv
// spi_reg_loader
// Receives a two-wire serial stream (spi_clk, spi_data) from asynchronous
// pins, deserializes it MSB-first into ADDR_W+DATA_W bit words and turns
// each completed word into a one-cycle register write strobe. There is no
// chip-select: a partial word is dropped after TIMEOUT_CYCLES clk cycles
// without a spi_clk rising edge.
//
// Ports:
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   spi_clk    raw serial clock pin (asynchronous)
//   spi_data   raw serial data pin (asynchronous)
//   wr_en      one-cycle write strobe
//   wr_addr    write address (held between strobes)
//   wr_data    write data (held between strobes)
//   busy       a partial word is being held
//   frame_err  one-cycle pulse when a partial word is dropped by timeout
//
// Handshake: wr_en is a push-only valid with no ready; the consumer must
// accept wr_addr/wr_data in every cycle wr_en is high.
//
// The receive FSM state is kept in the 'state' variable so checkers can
// bind to it directly.
module spi_reg_loader #(
    parameter int SYNC_STAGES    = 2,
    parameter int ADDR_W         = 8,
    parameter int DATA_W         = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              spi_clk,
    input  logic              spi_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              frame_err
);

    localparam int WORD_W = ADDR_W + DATA_W;
    localparam int CNT_W  = $clog2(WORD_W);
    localparam int TO_W   = $clog2(TIMEOUT_CYCLES);

    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(WORD_W - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic {
        ST_IDLE      = 1'b0,
        ST_RECEIVING = 1'b1
    } state_t;

    state_t state;

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    // Fills with ones after reset; an edge is only trusted once both the
    // synchronized clock and the previous-clock flop hold real pin samples.
    // This stops a spi_clk that is already high at release from looking
    // like a rising edge out of the zeroed synchronizer.
    logic [SYNC_STAGES:0]   sync_vld;
    logic                   prev_clk;

    // Only WORD_W-1 bits need storing: the last bit of a word is taken
    // straight from the synchronizer in the completing cycle.
    logic [WORD_W-2:0]      shift_reg;
    logic [CNT_W-1:0]       bit_cnt;
    logic [TO_W-1:0]        to_cnt;

    logic                   sync_clk;
    logic                   sync_data;
    logic                   rise;
    logic [WORD_W-1:0]      next_word;

    assign sync_clk  = clk_sync[SYNC_STAGES-1];
    assign sync_data = data_sync[SYNC_STAGES-1];
    assign rise      = sync_vld[SYNC_STAGES] & sync_clk & ~prev_clk;
    assign next_word = {shift_reg, sync_data};

    // Equal-depth synchronizers keep clock and data aligned.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync  <= '0;
            data_sync <= '0;
            sync_vld  <= '0;
            prev_clk  <= 1'b0;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], spi_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], spi_data};
            sync_vld  <= {sync_vld[SYNC_STAGES-1:0], 1'b1};
            prev_clk  <= sync_clk;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
            to_cnt    <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            busy      <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            wr_en     <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    to_cnt <= '0;
                    if (rise) begin
                        shift_reg <= next_word[WORD_W-2:0];
                        bit_cnt   <= CNT_W'(1);
                        busy      <= 1'b1;
                        state     <= ST_RECEIVING;
                    end
                end
                ST_RECEIVING: begin
                    // An edge on the terminal-count cycle wins over timeout.
                    if (rise) begin
                        shift_reg <= next_word[WORD_W-2:0];
                        to_cnt    <= '0;
                        if (bit_cnt == BIT_LAST) begin
                            bit_cnt <= '0;
                            busy    <= 1'b0;
                            wr_en   <= 1'b1;
                            wr_addr <= next_word[WORD_W-1:DATA_W];
                            wr_data <= next_word[DATA_W-1:0];
                            state   <= ST_IDLE;
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end else if (to_cnt == TO_LAST) begin
                        bit_cnt   <= '0;
                        to_cnt    <= '0;
                        busy      <= 1'b0;
                        frame_err <= 1'b1;
                        state     <= ST_IDLE;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_reg_loader.sv
// Testbench for spi_reg_loader. Serial words are driven on the raw pins;
// a reference model working on raw edge times and bit lists predicts the
// write / frame-error events, which are compared against the events seen
// on the DUT outputs.
module tb_spi_reg_loader;

    localparam int S  = 2;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam int WW = AW + DW;
    localparam int TC = 64;
    localparam logic [16:0] EV_FRAME = 17'h10000;

    // clock / reset
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic spi_clk = 1'b0;
    logic spi_data = 1'b0;
    logic wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic busy;
    logic frame_err;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    spi_reg_loader #(
        .SYNC_STAGES(S),
        .ADDR_W(AW),
        .DATA_W(DW),
        .TIMEOUT_CYCLES(TC)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .spi_clk(spi_clk),
        .spi_data(spi_data),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .busy(busy),
        .frame_err(frame_err)
    );

    int n_checks = 0;
    int n_fail = 0;

    // scoreboard: events are {is_frame, word}
    logic [16:0] exp_q[$];
    logic [16:0] obs_q[$];

    // reference model state
    int          m_cnt = 0;
    logic [15:0] m_word = '0;
    int          m_last = 0;
    logic [15:0] m_last_wr = '0;

    function automatic void model_edge(input logic b, input int t);
        if (m_cnt != 0 && (t - m_last) > TC) begin
            exp_q.push_back(EV_FRAME);
            m_cnt = 0;
        end
        m_word = {m_word[14:0], b};
        m_cnt  = m_cnt + 1;
        m_last = t;
        if (m_cnt == WW) begin
            exp_q.push_back({1'b0, m_word});
            m_last_wr = m_word;
            m_cnt = 0;
        end
    endfunction

    // monitor
    logic prev_wr = 1'b0;
    logic prev_fe = 1'b0;
    always @(negedge clk) begin
        if (reset_n) begin
            if (wr_en) begin
                obs_q.push_back({1'b0, wr_addr, wr_data});
                n_checks = n_checks + 1;
                assert (prev_wr === 1'b0) else begin
                    n_fail = n_fail + 1;
                    $error("FAIL wr_en_width obs=%b exp=%b", prev_wr, 1'b0);
                end
            end
            if (frame_err) begin
                obs_q.push_back(EV_FRAME);
                n_checks = n_checks + 1;
                assert (prev_fe === 1'b0) else begin
                    n_fail = n_fail + 1;
                    $error("FAIL frame_err_width obs=%b exp=%b", prev_fe, 1'b0);
                end
            end
        end
        prev_wr = wr_en;
        prev_fe = frame_err;
    end

    // driver tasks (called at a negedge)
    task automatic send_bit(input logic b, input int lo, input int hi);
        logic exp_busy;
        spi_data = b;
        spi_clk  = 1'b0;
        repeat (lo) @(negedge clk);
        spi_clk = 1'b1;
        model_edge(b, cyc);
        repeat (hi) @(negedge clk);
        exp_busy = (m_cnt != 0);
        n_checks = n_checks + 1;
        assert (busy === exp_busy) else begin
            n_fail = n_fail + 1;
            $error("FAIL busy obs=%b exp=%b", busy, exp_busy);
        end
    endtask

    task automatic send_word(input logic [15:0] w, input int lo, input int hi);
        for (int i = WW - 1; i >= 0; i--) send_bit(w[i], lo, hi);
    endtask

    task automatic send_rand_bits(input int n, input int lo, input int hi);
        for (int i = 0; i < n; i++) send_bit(1'($urandom_range(0, 1)), lo, hi);
    endtask

    task automatic flush_idle();
        spi_clk = 1'b0;
        repeat (TC + S + 10) @(negedge clk);
        if (m_cnt != 0) begin
            exp_q.push_back(EV_FRAME);
            m_cnt = 0;
        end
    endtask

    task automatic check_events(input string name);
        logic [16:0] o;
        logic [16:0] e;
        logic exp_busy;
        repeat (3) @(negedge clk);
        n_checks = n_checks + 1;
        assert (obs_q.size() === exp_q.size()) else begin
            n_fail = n_fail + 1;
            $error("FAIL %s event_count obs=%0d exp=%0d", name, obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            n_checks = n_checks + 1;
            assert (o === e) else begin
                n_fail = n_fail + 1;
                $error("FAIL %s event obs=%h exp=%h", name, o, e);
            end
        end
        exp_q.delete();
        obs_q.delete();
        n_checks = n_checks + 1;
        assert ({wr_addr, wr_data} === m_last_wr) else begin
            n_fail = n_fail + 1;
            $error("FAIL %s hold obs=%h exp=%h", name, {wr_addr, wr_data}, m_last_wr);
        end
        exp_busy = (m_cnt != 0);
        n_checks = n_checks + 1;
        assert (busy === exp_busy) else begin
            n_fail = n_fail + 1;
            $error("FAIL %s busy obs=%b exp=%b", name, busy, exp_busy);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        n_checks = n_checks + 1;
        assert ({wr_en, wr_addr, wr_data, busy, frame_err} === '0) else begin
            n_fail = n_fail + 1;
            $error("FAIL %s outputs obs=%b_%h_%h_%b_%b exp=0", name,
                   wr_en, wr_addr, wr_data, busy, frame_err);
        end
    endtask

    initial begin
        // reset state
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        check_events("post_reset");

        // single word
        send_word(16'h12A5, 8, 8);
        spi_clk = 1'b0;
        check_events("single");

        // back-to-back words
        send_word(16'h0001, 8, 8);
        send_word(16'hFFFE, 8, 8);
        send_word(16'h8080, 8, 8);
        spi_clk = 1'b0;
        check_events("back_to_back");

        // timeout on a 7-bit partial word, then a clean word
        send_rand_bits(7, 8, 8);
        flush_idle();
        check_events("timeout");
        send_word(16'h3C5A, 8, 8);
        spi_clk = 1'b0;
        check_events("after_timeout");

        // 8th edge lands exactly on the terminal count: no frame error
        send_rand_bits(7, 8, 8);
        send_bit(1'($urandom_range(0, 1)), TC - 8, 8);
        send_rand_bits(8, 8, 8);
        spi_clk = 1'b0;
        check_events("tc_edge");

        // one cycle later: partial word dropped, the late edge starts a new word
        send_rand_bits(7, 8, 8);
        send_bit(1'($urandom_range(0, 1)), TC - 7, 8);
        send_rand_bits(8, 8, 8);
        flush_idle();
        check_events("tc_plus1");

        // reset mid-word, released while spi_clk is high
        send_rand_bits(10, 8, 8);
        reset_n = 1'b0;
        m_cnt = 0;
        m_last_wr = '0;
        repeat (4) @(negedge clk);
        check_reset_outputs("mid_reset");
        reset_n = 1'b1;
        repeat (6) @(negedge clk);
        send_word(16'h4455, 8, 8);
        spi_clk = 1'b0;
        check_events("reset_mid_word");

        // minimum-timing sweep
        for (int k = 0; k < 100; k++) send_word(16'($urandom), S + 1, S + 1);
        spi_clk = 1'b0;
        check_events("min_timing");

        // random legal timing
        for (int k = 0; k < 20; k++)
            send_word(16'($urandom), $urandom_range(S + 1, 12), $urandom_range(S + 1, 12));
        spi_clk = 1'b0;
        check_events("random_timing");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
